// File: rtl/hps_hex_key_responder.sv
// hps_hex_key_responder: Avalon-MM six-digit seven-segment driver with double-dabble conversion and debounced key interrupts
module hps_hex_key_responder #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W = 16
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [2:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        avs_waitrequest,
  output logic        irq,
  input  logic [3:0]  key_in,
  output logic [13:0] hex_0_out,
  output logic [13:0] hex_1_out,
  output logic [13:0] hex_2_out
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [23:0] value, bin, bcd, adj, digits, hexd, shown;
  logic [4:0] cnt;
  logic [2:0] ctrl;
  logic [3:0] edges, mask, sync1, sync2, pressed, lvl, hit, rise, w1c;
  logic [CNT_W-1:0] dcnt [4];
  logic [5:0] blanked;
  logic [6:0] seg [6];
  logic [31:0] rd_mux;
  logic busy, start, lead, unused;
  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'h0: dec = 7'h40;
      4'h1: dec = 7'h79;
      4'h2: dec = 7'h24;
      4'h3: dec = 7'h30;
      4'h4: dec = 7'h19;
      4'h5: dec = 7'h12;
      4'h6: dec = 7'h02;
      4'h7: dec = 7'h78;
      4'h8: dec = 7'h00;
      4'h9: dec = 7'h10;
      4'hA: dec = 7'h08;
      4'hB: dec = 7'h03;
      4'hC: dec = 7'h46;
      4'hD: dec = 7'h21;
      4'hE: dec = 7'h06;
      default: dec = 7'h0E;
    endcase
  endfunction
  assign unused = ^avs_writedata[31:24];
  assign busy = state != IDLE;
  assign start = avs_write && avs_address == 3'd0 && !busy;
  assign avs_waitrequest = avs_write && avs_address == 3'd0 && busy;
  assign w1c = avs_write && avs_address == 3'd3 ? avs_writedata[3:0] : 4'd0;
  assign pressed = ~sync2;
  always_ff @(posedge clk_clk)
    state <= reset_reset ? IDLE : state_nx;
  always_comb begin
    state_nx = start ? SHIFT : state == SHIFT && cnt == 5'd23 ? DONE : state == DONE ? IDLE : state;
  end
  always_comb begin
    adj = bcd;
    for (int k = 0; k < 6; k++)
      adj[4*k+:4] = bcd[4*k+:4] >= 4'd5 ? bcd[4*k+:4] + 4'd3 : bcd[4*k+:4];
  end
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      value <= '0;
      bin <= '0;
      bcd <= '0;
      cnt <= '0;
      digits <= '0;
      hexd <= '0;
    end else begin
      if (start) begin
        value <= avs_writedata[23:0];
        bin <= avs_writedata[23:0] > 24'd999999 ? 24'd999999 : avs_writedata[23:0];
        bcd <= '0;
        cnt <= '0;
      end else if (state == SHIFT) begin
        {bcd, bin} <= {adj[22:0], bin, 1'b0};
        cnt <= cnt + 5'd1;
      end
      if (state == DONE) begin
        digits <= bcd;
        hexd <= value;
      end
    end
  end
  assign rd_mux = avs_address == 3'd0 ? {8'd0, value} :
                  avs_address == 3'd1 ? {29'd0, ctrl} :
                  avs_address == 3'd2 ? {24'd0, lvl, 3'd0, busy} :
                  avs_address == 3'd3 ? {28'd0, edges} :
                  avs_address == 3'd4 ? {28'd0, mask} : 32'd0;
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      ctrl <= 3'b100;
      mask <= '0;
      avs_readdata <= '0;
      edges <= '0;
      irq <= 1'b0;
    end else begin
      if (avs_write && avs_address == 3'd1)
        ctrl <= avs_writedata[2:0];
      if (avs_write && avs_address == 3'd4)
        mask <= avs_writedata[3:0];
      if (avs_read)
        avs_readdata <= rd_mux;
      edges <= (edges & ~w1c) | rise;
      irq <= |(edges & mask);
    end
  end
  always_comb begin
    hit = '0;
    for (int k = 0; k < 4; k++)
      hit[k] = pressed[k] != lvl[k] && dcnt[k] == CNT_W'(DEBOUNCE_CYCLES - 1);
    rise = hit & ~lvl;
  end
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sync1 <= 4'hF;
      sync2 <= 4'hF;
      lvl <= '0;
      for (int k = 0; k < 4; k++)
        dcnt[k] <= '0;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
      lvl <= lvl ^ hit;
      for (int k = 0; k < 4; k++)
        dcnt[k] <= pressed[k] == lvl[k] || hit[k] ? '0 : dcnt[k] + CNT_W'(1);
    end
  end
  assign shown = ctrl[0] ? hexd : digits;
  always_comb begin
    lead = 1'b1;
    blanked = '0;
    for (int k = 5; k >= 1; k--) begin
      lead = lead && shown[4*k+:4] == 4'd0;
      blanked[k] = lead && ctrl[1];
    end
    for (int k = 0; k < 6; k++)
      seg[k] = !ctrl[2] || blanked[k] ? 7'h7F : dec(shown[4*k+:4]);
  end
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      hex_0_out <= 14'h2040;
      hex_1_out <= 14'h2040;
      hex_2_out <= 14'h2040;
    end else begin
      hex_0_out <= {seg[1], seg[0]};
      hex_1_out <= {seg[3], seg[2]};
      hex_2_out <= {seg[5], seg[4]};
    end
  end
endmodule

// File: tb/tb_hps_hex_key_responder.sv
// tb_hps_hex_key_responder: directed checks of conversion, display, register map and key debounce/irq
module tb_hps_hex_key_responder;
  logic clk_clk = 1'b0;
  logic reset_reset, avs_read, avs_write, avs_waitrequest, irq;
  logic [2:0] avs_address;
  logic [31:0] avs_writedata, avs_readdata, d;
  logic [3:0] key_in;
  logic [13:0] hex_0_out, hex_1_out, hex_2_out;
  int vectors = 0;
  int miscompares = 0;
  hps_hex_key_responder #(.DEBOUNCE_CYCLES(16), .CNT_W(5)) dut (
    .clk_clk(clk_clk),
    .reset_reset(reset_reset),
    .avs_address(avs_address),
    .avs_read(avs_read),
    .avs_write(avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata(avs_readdata),
    .avs_waitrequest(avs_waitrequest),
    .irq(irq),
    .key_in(key_in),
    .hex_0_out(hex_0_out),
    .hex_1_out(hex_1_out),
    .hex_2_out(hex_2_out)
  );
  always #5 clk_clk = ~clk_clk;
  task automatic tick;
    @(posedge clk_clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] v);
    avs_address = a;
    avs_writedata = v;
    avs_write = 1'b1;
    tick();
    avs_write = 1'b0;
  endtask
  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    avs_address = a;
    avs_read = 1'b1;
    tick();
    avs_read = 1'b0;
    v = avs_readdata;
  endtask
  initial begin
    reset_reset = 1'b1;
    avs_read = 1'b0;
    avs_write = 1'b0;
    avs_address = '0;
    avs_writedata = '0;
    key_in = 4'hF;
    repeat (2) tick();
    chk("rst_readdata", avs_readdata, 32'h0);
    reset_reset = 1'b0;
    chk("rst_hex0", hex_0_out, 14'h2040);
    chk("rst_hex1", hex_1_out, 14'h2040);
    chk("rst_hex2", hex_2_out, 14'h2040);
    chk("rst_irq", irq, 1'b0);
    chk("rst_wait", avs_waitrequest, 1'b0);
    rd(3'd2, d);
    chk("rst_status", d, 32'h0);
    rd(3'd1, d);
    chk("rst_ctrl", d, 32'h4);
    wr(3'd5, 32'hFFFF_FFFF);
    rd(3'd5, d);
    chk("addr5_read", d, 32'h0);
    wr(3'd0, 32'd123456);
    rd(3'd2, d);
    chk("busy_status", d, 32'h1);
    avs_address = 3'd0;
    avs_write = 1'b1;
    #1;
    chk("busy_wait", avs_waitrequest, 1'b1);
    avs_write = 1'b0;
    repeat (23) tick();
    chk("hex0_e24", hex_0_out, 14'h2040);
    tick();
    chk("hex0_e25", hex_0_out, 14'h2040);
    avs_write = 1'b1;
    #1;
    chk("idle_wait", avs_waitrequest, 1'b0);
    avs_write = 1'b0;
    tick();
    chk("dec_hex2", hex_2_out, 14'h3CA4);
    chk("dec_hex1", hex_1_out, 14'h1819);
    chk("dec_hex0", hex_0_out, 14'h0902);
    wr(3'd0, 32'd1500000);
    repeat (26) tick();
    chk("clamp_hex2", hex_2_out, 14'h0810);
    chk("clamp_hex1", hex_1_out, 14'h0810);
    chk("clamp_hex0", hex_0_out, 14'h0810);
    rd(3'd0, d);
    chk("value_read", d, 32'd1500000);
    repeat (2) tick();
    chk("readdata_hold", avs_readdata, 32'd1500000);
    wr(3'd0, 32'h00ABCD);
    repeat (26) tick();
    chk("abcd_dec_hex2", hex_2_out, 14'h2019);
    wr(3'd1, 32'h7);
    tick();
    chk("hexb_hex2", hex_2_out, 14'h3FFF);
    chk("hexb_hex1", hex_1_out, 14'h0403);
    chk("hexb_hex0", hex_0_out, 14'h2321);
    wr(3'd1, 32'h5);
    tick();
    chk("hexnb_hex2", hex_2_out, 14'h2040);
    wr(3'd1, 32'h3);
    tick();
    chk("dis_hex2", hex_2_out, 14'h3FFF);
    chk("dis_hex1", hex_1_out, 14'h3FFF);
    chk("dis_hex0", hex_0_out, 14'h3FFF);
    wr(3'd4, 32'h4);
    for (int i = 0; i < 20; i++) begin
      key_in[2] = ~key_in[2];
      repeat (5) tick();
    end
    rd(3'd3, d);
    chk("bounce_edge", d, 32'h0);
    chk("bounce_irq", irq, 1'b0);
    key_in[2] = 1'b0;
    repeat (30) tick();
    rd(3'd3, d);
    chk("press_edge", d, 32'h4);
    rd(3'd2, d);
    chk("press_status", d, 32'h40);
    chk("press_irq", irq, 1'b1);
    wr(3'd3, 32'h4);
    chk("w1c_irq_lag", irq, 1'b1);
    tick();
    chk("w1c_irq_low", irq, 1'b0);
    repeat (10) tick();
    rd(3'd3, d);
    chk("held_edge", d, 32'h0);
    key_in[2] = 1'b1;
    repeat (30) tick();
    rd(3'd3, d);
    chk("release_edge", d, 32'h0);
    rd(3'd2, d);
    chk("release_status", d, 32'h0);
    wr(3'd0, 32'd777777);
    repeat (9) tick();
    reset_reset = 1'b1;
    tick();
    reset_reset = 1'b0;
    chk("midrst_hex0", hex_0_out, 14'h2040);
    chk("midrst_hex2", hex_2_out, 14'h2040);
    rd(3'd2, d);
    chk("midrst_status", d, 32'h0);
    rd(3'd1, d);
    chk("midrst_ctrl", d, 32'h4);
    wr(3'd0, 32'd42);
    repeat (26) tick();
    chk("v42_hex0", hex_0_out, 14'h0CA4);
    chk("v42_hex1", hex_1_out, 14'h2040);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
